// File: rtl/mux_pipe_pkg.sv
// ============================================================================
// Module : mux_pipe_pkg
// Brief  : Shared defaults and select-mode encodings for the N:1 pipelined
//          mux and for the PC/RD select logic that reuses them.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_pipe_pkg;

  localparam int MUX_PIPE_WIDTH_DEFAULT = 32;
  localparam int MUX_PIPE_N_DEFAULT     = 4;

  // What an out-of-range select produces.
  typedef enum logic [0:0] {
    SEL_MODE_CLAMP = 1'b0,  // forward the highest-numbered input
    SEL_MODE_ZERO  = 1'b1   // forward all-zero data and flag the error
  } sel_mode_e;

  // True when a select value does not address one of the n inputs.
  function automatic logic sel_out_of_range(input logic [31:0] sel,
                                            input int unsigned n);
    return (sel >= n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/skid_buf.sv
// ============================================================================
// Module : skid_buf
// Brief  : Two-entry skid buffer (output register + skid register).
//          in_ready is a pure register output, so there is no combinational
//          path from out_ready back to the upstream side.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module skid_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;

  logic accept;
  logic xfer;

  assign in_ready  = ~skid_valid_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid_q & out_ready;

  // Next state: refill the output stage from skid first, else from input.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      // Data registers keep their last contents; only the valids drop.
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || xfer) begin
      if (skid_valid_q) begin
        // Skid holds the older entry; in_ready is low so no accept here.
        out_data_d   = skid_data_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_data_d  = in_data;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      // Output stalled: park the new entry in the skid register.
      skid_data_d  = in_data;
      skid_valid_d = 1'b1;
    end
  end

  // State registers; reset overrides flush and any accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_pipe_nx1.sv
// ============================================================================
// Module : mux_pipe_nx1
// Brief  : N:1 mux with a one-cycle registered, skid-buffered output.
//          The select is resolved when an entry is accepted.
//          Optional macro MUX_PIPE_SEL_CHECK_EN: out-of-range selects store
//          zero and raise the sticky sel_err output (cleared only by rst).
//          Without it, out-of-range selects forward input N-1.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_pipe_nx1
  import mux_pipe_pkg::*;
#(
  parameter  int WIDTH = MUX_PIPE_WIDTH_DEFAULT,
  parameter  int N     = MUX_PIPE_N_DEFAULT,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]    in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
`ifdef MUX_PIPE_SEL_CHECK_EN
  output logic               sel_err,
`endif
  input  logic               out_ready
);

`ifdef MUX_PIPE_SEL_CHECK_EN
  localparam sel_mode_e SEL_MODE = SEL_MODE_ZERO;
`else
  localparam sel_mode_e SEL_MODE = SEL_MODE_CLAMP;
`endif

  logic [WIDTH-1:0] sel_data;

  // Select the addressed input; out-of-range falls to the mode default.
  always_comb begin
    sel_data = (SEL_MODE == SEL_MODE_ZERO) ? '0 : in_data[(N-1)*WIDTH +: WIDTH];
    for (int k = 0; k < N; k++) begin
      if (32'(in_sel) == 32'(k)) sel_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  skid_buf #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_data   (sel_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

`ifdef MUX_PIPE_SEL_CHECK_EN
  logic sel_err_q, sel_err_d;

  // Sticky error: set by any accepted out-of-range select, even if flushed.
  always_comb begin
    sel_err_d = sel_err_q;
    if (in_valid && in_ready && sel_out_of_range(32'(in_sel), N)) sel_err_d = 1'b1;
  end

  // Error flag register; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) sel_err_q <= 1'b0;
    else     sel_err_q <= sel_err_d;
  end

  assign sel_err = sel_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_pipe_nx1.sv
// ============================================================================
// Module : tb_mux_pipe_nx1
// Brief  : Self-checking bench for mux_pipe_nx1. Five instances (N = 4, 5,
//          2, 3, 8) share one handshake stimulus; each is compared every
//          cycle against a queue-based reference model.
//          Honours MUX_PIPE_SEL_CHECK_EN like the design.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_pipe_nx1;

  localparam int NI = 5;
  localparam int NS [NI] = '{4, 5, 2, 3, 8};
`ifdef MUX_PIPE_SEL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] din;
  logic [3:0]   tsel;
  logic         vin;
  logic         flush;
  logic         ordy;

  logic [31:0]  od [NI];
  logic         ov [NI];
  logic         ir [NI];
  logic         se [NI];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: pending entries, visible out_data, sticky error.
  logic [31:0] mq    [NI][$];
  logic [31:0] shown [NI];
  logic        err   [NI];

  always #5 clk = ~clk;

  for (genvar i = 0; i < NI; i++) begin : g_dut
    localparam int NN = NS[i];
    localparam int SW = $clog2(NN);
    mux_pipe_nx1 #(
      .WIDTH (32),
      .N     (NN)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (din[NN*32-1:0]),
      .in_sel    (tsel[SW-1:0]),
      .in_valid  (vin),
      .in_ready  (ir[i]),
      .flush     (flush),
      .out_data  (od[i]),
      .out_valid (ov[i]),
`ifdef MUX_PIPE_SEL_CHECK_EN
      .sel_err   (se[i]),
`endif
      .out_ready (ordy)
    );
`ifndef MUX_PIPE_SEL_CHECK_EN
    assign se[i] = 1'b0;
`endif
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Value an n-input mux must capture for the current select.
  function automatic logic [31:0] exp_data(input int n);
    int          sw = $clog2(n);
    int unsigned s  = 32'(tsel) & ((32'd1 << sw) - 1);
    if (s < n) return din[s*32 +: 32];
    return CHK ? 32'd0 : din[(n-1)*32 +: 32];
  endfunction

  function automatic bit oor(input int n);
    int          sw = $clog2(n);
    int unsigned s  = 32'(tsel) & ((32'd1 << sw) - 1);
    return (s >= n);
  endfunction

  // Advance the model by one clock using the inputs presented this cycle.
  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      bit acc = vin && (mq[i].size() < 2);
      bit xf  = (mq[i].size() > 0) && ordy;
      if (rst) begin
        mq[i].delete();
        shown[i] = 32'd0;
        err[i]   = 1'b0;
      end else begin
        if (acc && CHK && oor(NS[i])) err[i] = 1'b1;
        if (flush) mq[i].delete();
        else begin
          if (xf)  void'(mq[i].pop_front());
          if (acc) mq[i].push_back(exp_data(NS[i]));
        end
        if (mq[i].size() > 0) shown[i] = mq[i][0];
      end
    end
  endtask

  // One clock: update the model at the edge, then compare every instance.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("out_valid[%0d]", i), 32'(ov[i]), 32'(mq[i].size() > 0));
      check($sformatf("in_ready[%0d]", i),  32'(ir[i]), 32'(mq[i].size() < 2));
      check($sformatf("out_data[%0d]", i),  od[i], shown[i]);
`ifdef MUX_PIPE_SEL_CHECK_EN
      check($sformatf("sel_err[%0d]", i),   32'(se[i]), 32'(err[i]));
`endif
    end
  endtask

  task automatic set_pattern();
    for (int k = 0; k < 8; k++) din[k*32 +: 32] = 32'(k + 1) * 32'h11;
  endtask

  initial begin
    rst = 1'b1; vin = 1'b0; flush = 1'b0; ordy = 1'b0; tsel = '0;
    din = '0;
    for (int i = 0; i < NI; i++) begin
      shown[i] = 32'd0;
      err[i]   = 1'b0;
    end
    step(); step();
    rst = 1'b0;
    check("reset_ov",   32'(ov[0]), 32'd0);
    check("reset_od",   od[0],      32'd0);
    check("reset_rdy",  32'(ir[0]), 32'd1);

    // Back-to-back stream, sel 0..3 on consecutive cycles.
    set_pattern();
    ordy = 1'b1; vin = 1'b1;
    for (int s = 0; s < 4; s++) begin
      tsel = 4'(s);
      step();
      check("stream_data",  od[0],      32'(s + 1) * 32'h11);
      check("stream_valid", 32'(ov[0]), 32'd1);
    end
    vin = 1'b0;
    step();

    // Stall: second accept lands in skid, in_ready drops.
    ordy = 1'b0; vin = 1'b1; tsel = 4'd1;
    step();
    tsel = 4'd2;
    step();
    vin = 1'b0;
    check("stall_hold", od[0],      32'h22);
    check("stall_rdy",  32'(ir[0]), 32'd0);
    step();
    check("stall_hold2", od[0], 32'h22);
    ordy = 1'b1;
    step();
    check("drain_skid", od[0],      32'h33);
    check("drain_rdy",  32'(ir[0]), 32'd1);
    step();
    check("drain_empty", 32'(ov[0]), 32'd0);

    // Both stages full, then flush with a same-cycle offer.
    ordy = 1'b0; vin = 1'b1; tsel = 4'd0;
    step();
    tsel = 4'd3;
    step();
    flush = 1'b1; tsel = 4'd1;
    step();
    flush = 1'b0; vin = 1'b0;
    check("flush_ov",  32'(ov[0]), 32'd0);
    check("flush_rdy", 32'(ir[0]), 32'd1);
    ordy = 1'b1;
    step();
    check("flush_drop", 32'(ov[0]), 32'd0);

    // Reset while two entries are buffered.
    ordy = 1'b0; vin = 1'b1; tsel = 4'd2;
    step();
    step();
    rst = 1'b1; ordy = 1'b1;
    step();
    rst = 1'b0; vin = 1'b0;
    check("rst_ov",  32'(ov[0]), 32'd0);
    check("rst_od",  od[0],      32'd0);
    check("rst_rdy", 32'(ir[0]), 32'd1);
    step();
    check("rst_noemit", 32'(ov[0]), 32'd0);

    // Out-of-range select on the N=5 instance.
    vin = 1'b1; tsel = 4'd7;
    step();
    vin = 1'b0;
    check("oor_data", od[1], CHK ? 32'd0 : 32'h55);
`ifdef MUX_PIPE_SEL_CHECK_EN
    check("oor_err", 32'(se[1]), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("oor_sticky", 32'(se[1]), 32'd1);
`endif
    step();

    // Randomised handshake, data, select, flush and occasional reset.
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 8; k++) din[k*32 +: 32] = $urandom;
      tsel  = 4'($urandom_range(0, 15));
      vin   = ($urandom_range(0, 3) != 0);
      ordy  = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 31) == 0);
      rst   = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0; flush = 1'b0; vin = 1'b0; ordy = 1'b1;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
